// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: instruction memory read port, redirect strobe and the
// handshake toward decode. The fetch stage uses the master view; whatever
// sits around it (memory, decode, branch unit or a testbench) uses slave.
interface fetch_stage_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_INST_WIDTH = 32
);

  logic                      mem_req;
  logic [BUS_DATA_WIDTH-1:0] mem_addr;
  logic                      mem_ack;
  logic [BUS_INST_WIDTH-1:0] mem_rdata;

  logic                      redirect_valid;
  logic [BUS_DATA_WIDTH-1:0] redirect_pc;

  logic                      id_stall;
  logic                      id_read;
  logic                      if_write;
  logic [BUS_INST_WIDTH-1:0] inst;
  logic [BUS_DATA_WIDTH-1:0] out_PCplus4;
  logic                      fetch_empty;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  redirect_valid, redirect_pc,
    input  id_stall, id_read,
    output if_write, inst, out_PCplus4, fetch_empty
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output redirect_valid, redirect_pc,
    output id_stall, id_read,
    input  if_write, inst, out_PCplus4, fetch_empty
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: walks a word-aligned fetch PC, issues reads to
// instruction memory and buffers returned words (with their PC+4) for decode.
// Build option FETCH_PREFETCH_EN: when defined the buffer holds two entries so
// fetch can run one instruction ahead of a stalled decode; when undefined the
// buffer holds one entry and a new request is only made once it drains.
// Reset is synchronous and active-high and wins over a redirect.
module fetch_stage #(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter int                        BUS_INST_WIDTH = 32,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetchState_t;

  fetchState_t r_state;
  fetchState_t w_nextState;

  logic [BUS_DATA_WIDTH-1:0] r_fpc;
  logic [BUS_INST_WIDTH-1:0] r_bufInst [DEPTH];
  logic [BUS_DATA_WIDTH-1:0] r_bufPc   [DEPTH];
  logic [1:0]                r_count;

  logic                      w_memReq;
  logic                      w_push;
  logic                      w_pop;
  logic [1:0]                w_countAfter;
  logic [1:0]                w_pushIdx;
  logic [BUS_DATA_WIDTH-1:0] w_fpcPlus4;
  logic [BUS_DATA_WIDTH-1:0] w_redirTarget;

  // A redirect throws away both the returning word and any decode transfer.
  assign w_fpcPlus4    = r_fpc + BUS_DATA_WIDTH'(4);
  assign w_redirTarget = bus.redirect_pc & ~BUS_DATA_WIDTH'(3);
  assign w_push        = w_memReq & bus.mem_ack & ~bus.redirect_valid;
  assign w_pop         = (r_count != 2'd0) & bus.id_read & ~bus.id_stall
                         & ~bus.redirect_valid;
  assign w_countAfter  = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_pushIdx     = r_count - {1'b0, w_pop};

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: keep requesting while the buffer has room, park when full.
  always_comb begin
    w_nextState = r_state;
    if (bus.redirect_valid) begin
      w_nextState = REQ;
    end else begin
      case (r_state)
        IDLE: w_nextState = REQ;
        REQ: begin
          if (w_push && (w_countAfter == FULL_COUNT)) begin
            w_nextState = WAIT;
          end
        end
        WAIT: begin
          if (w_pop) begin
            w_nextState = REQ;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // FSM outputs: the read request is only raised from the REQ state.
  always_comb begin
    w_memReq = 1'b0;
    case (r_state)
      REQ:     w_memReq = 1'b1;
      default: w_memReq = 1'b0;
    endcase
  end

  // Fetch PC: load the aligned redirect target, else step on each accepted word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_fpc <= w_redirTarget;
    end else if (w_push) begin
      r_fpc <= w_fpcPlus4;
    end
  end

  // Occupancy of the instruction buffer; a redirect empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
    end else if (bus.redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      r_count <= w_countAfter;
    end
  end

  // Buffer storage: shift toward the head on a pop, write the new word behind the survivors.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bufInst[i] <= '0;
        r_bufPc[i]   <= '0;
      end
    end else if (!bus.redirect_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pop) begin
          r_bufInst[i] <= r_bufInst[(i + 1 < DEPTH) ? i + 1 : i];
          r_bufPc[i]   <= r_bufPc[(i + 1 < DEPTH) ? i + 1 : i];
        end
        if (w_push && (w_pushIdx == 2'(i))) begin
          r_bufInst[i] <= bus.mem_rdata;
          r_bufPc[i]   <= w_fpcPlus4;
        end
      end
    end
  end

  assign bus.mem_req     = w_memReq;
  assign bus.mem_addr    = r_fpc;
  assign bus.if_write    = (r_count != 2'd0);
  assign bus.fetch_empty = (r_count == 2'd0);
  assign bus.inst        = r_bufInst[0];
  assign bus.out_PCplus4 = r_bufPc[0];

endmodule
